mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_beat_seq.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and widths for the memory port arbiter:
//               arbiter FSM state encoding and address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_B0  = 2'd2,
    DM_B1  = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_beat_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_beat_seq
// Description : Beat sequencer for the shared memory port. Holds the
//               registered memory address and the beat index; steps the
//               address by one word (wrapping mod 2^ADDR_W) for the second
//               beat of a double-word access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_beat_seq
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              adv_i,
  input  logic              done_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              beat_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              beat_q, beat_d;

  // Next address/beat: load on grant, step on first-beat completion, clear when done.
  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    if (load_i) begin
      addr_d = addr_i;
      beat_d = 1'b0;
    end else if (adv_i) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      beat_d = 1'b1;
    end else if (done_i) begin
      beat_d = 1'b0;
    end
  end

  // Address and beat registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      beat_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end

  assign addr_o = addr_q;
  assign beat_o = beat_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one shared single-word memory port between the
//               instruction fetch and the data port. Data wins ties; double
//               word accesses run as two back-to-back beats with the strobe
//               held continuously.
//               Optional: define MEM_ARB_ALIGN_CHK_EN to reject double-word
//               requests at odd word addresses with a dm_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic                dm_dbl,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [2*DATA_W-1:0] dm_wdata,
  output logic [2*DATA_W-1:0] dm_rdata,
  output logic                dm_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                beat,
  output logic                dm_err
);

  arb_state_e                state_q, state_d;
  logic                      we_q, we_d;
  logic                      dbl_q, dbl_d;
  logic [DATA_W-1:0]         wdata_hi_q, wdata_hi_d;
  logic [DATA_W-1:0]         lo_q, lo_d;
  logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [DATA_W-1:0]         if_rdata_q, if_rdata_d;
  logic [2*DATA_W-1:0]       dm_rdata_q, dm_rdata_d;
  logic                      if_valid_q, if_valid_d;
  logic                      dm_valid_q, dm_valid_d;
  logic                      dm_err_q, dm_err_d;

  logic                      seq_load, seq_adv, seq_done;
  logic [ADDR_W-1:0]         seq_addr;
  logic                      w_dm_go, w_if_go, w_misalign;

  // A requester whose valid pulse is showing is finishing, so its held req is not a new request.
  assign w_dm_go = dm_req & ~dm_valid_q;
  assign w_if_go = if_req & ~if_valid_q;

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign w_misalign = dm_dbl & dm_addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  mem_beat_seq u_beat_seq (
    .clk    (clk),
    .rst    (rst),
    .load_i (seq_load),
    .addr_i (seq_addr),
    .adv_i  (seq_adv),
    .done_i (seq_done),
    .addr_o (mem_addr),
    .beat_o (beat)
  );

  // Arbiter next-state, strobe, capture and pulse logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    dbl_d       = dbl_q;
    wdata_hi_d  = wdata_hi_q;
    lo_d        = lo_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    dm_err_d    = 1'b0;
    seq_load    = 1'b0;
    seq_adv     = 1'b0;
    seq_done    = 1'b0;
    seq_addr    = if_addr;
    case (state_q)
      IDLE: begin
        if (w_dm_go) begin
          we_d        = dm_we;
          dbl_d       = dm_dbl;
          wdata_hi_d  = dm_wdata[2*DATA_W-1:DATA_W];
          mem_wdata_d = dm_wdata[DATA_W-1:0];
          if (w_misalign) begin
            // Rejected without touching memory; report as a completed errored access.
            dm_err_d   = 1'b1;
            dm_valid_d = 1'b1;
          end else begin
            state_d     = DM_B0;
            seq_load    = 1'b1;
            seq_addr    = dm_addr;
            mem_read_d  = ~dm_we;
            mem_write_d = dm_we;
          end
        end else if (w_if_go) begin
          state_d     = IF_ACC;
          seq_load    = 1'b1;
          seq_addr    = if_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end
      end
      IF_ACC: begin
        if (mem_ready) begin
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end
      end
      DM_B0: begin
        if (mem_ready) begin
          if (dbl_q) begin
            // Strobe stays asserted; only address and write data move to the second word.
            lo_d        = mem_rdata;
            mem_wdata_d = wdata_hi_q;
            seq_adv     = 1'b1;
            state_d     = DM_B1;
          end else begin
            if (!we_q) dm_rdata_d = {{DATA_W{1'b0}}, mem_rdata};
            dm_valid_d  = 1'b1;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            seq_done    = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      DM_B1: begin
        if (mem_ready) begin
          if (!we_q) dm_rdata_d = {mem_rdata, lo_q};
          dm_valid_d  = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          seq_done    = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      dbl_q       <= 1'b0;
      wdata_hi_q  <= '0;
      lo_q        <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      dbl_q       <= dbl_d;
      wdata_hi_q  <= wdata_hi_d;
      lo_q        <= lo_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_err    = dm_err_q;
  assign busy      = (state_q != IDLE);

  // Requesters must keep req high while their access is in flight.
  a_if_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IF_ACC) |-> if_req);
  a_dm_hold: assert property (@(posedge clk) disable iff (!rst)
    ((state_q == DM_B0) || (state_q == DM_B1)) |-> dm_req);
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst)
    !(mem_read && mem_write));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: table of single
//               accesses plus hand-written contention, wrap/wait-state,
//               reset-abort and alignment-check sequences, with a scoreboard
//               of expected memory beats and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic        dm_dbl = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready;
  logic        busy;
  logic        beat;
  logic        dm_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt     = 0;
  int ws      = 0;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic        dbl;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic        is_dm;
    logic        err;
    logic [63:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        beat;
  } beat_t;

  resp_t       resp_q[$];
  beat_t       beat_q[$];
  logic [31:0] mem_model [logic [31:0]];
  vec_t        vecs[10];

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_dbl    (dm_dbl),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .beat      (beat),
    .dm_err    (dm_err)
  );

  always #5 clk = ~clk;

  // Memory model: ready after ws wait cycles of each beat.
  assign mem_ready = (cnt == ws);
  always @(posedge clk) begin
    if ((mem_read || mem_write) && !mem_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_access(input logic is_dm, input logic we, input logic dbl,
                             input logic [31:0] addr, input logic [63:0] wdata,
                             input logic [63:0] exp);
    beat_q.push_back('{addr, we, wdata[31:0], 1'b0});
    if (dbl) beat_q.push_back('{addr + 32'd1, we, wdata[63:32], 1'b1});
    resp_q.push_back('{is_dm, 1'b0, exp});
  endtask

  // Drives one request, waits (bounded) for its valid pulse, returns latency in cycles (0 = timeout).
  task automatic issue(input vec_t v, output int lat);
    lat = 0;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_dbl = v.dbl; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (v.is_dm ? dm_valid : if_valid) lat = k;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
  endtask

  // Scoreboard monitor: checks each completed memory beat and each valid pulse.
  initial begin
    resp_t r;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_read && mem_write) begin
          n_tests++; n_fail++;
          $display("FAIL strobe_excl: read=%b write=%b required not both", mem_read, mem_write);
        end
        if ((mem_read || mem_write) && mem_ready) begin
          if (beat_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL beat_unexpected: addr %h read %b write %b required no access", mem_addr, mem_read, mem_write);
          end else begin
            b = beat_q.pop_front();
            check("beat_addr", 64'(mem_addr), 64'(b.addr));
            check("beat_dir", 64'(mem_write), 64'(b.we));
            check("beat_idx", 64'(beat), 64'(b.beat));
            if (b.we) check("beat_wdata", 64'(mem_wdata), 64'(b.wdata));
          end
          if (mem_write) mem_model[mem_addr] = mem_wdata;
        end
        if (if_valid || dm_valid) begin
          if (resp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL valid_unexpected: if_valid %b dm_valid %b required none", if_valid, dm_valid);
          end else begin
            r = resp_q.pop_front();
            check("resp_kind", 64'(dm_valid), 64'(r.is_dm));
            if (dm_valid) begin
              check("dm_rdata", dm_rdata, r.rdata);
              check("dm_err", 64'(dm_err), 64'(r.err));
            end else begin
              check("if_rdata", 64'(if_rdata), r.rdata);
            end
          end
        end
        if (dm_err && !dm_valid) begin
          n_tests++; n_fail++;
          $display("FAIL dm_err_alone: dm_err %b dm_valid %b required err only with valid", dm_err, dm_valid);
        end
      end
      mem_rdata = mem_rd(mem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ld, li, n0, n1;
    logic seen_b1;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h00000010, 64'h0, 64'h00000000_A5A5A5A5};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h00000020, 64'h0, 64'h00000000_DEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h00000040, 64'h0, 64'h22222222_11111111};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h00000080, 64'h00000000_CAFEF00D, 64'h22222222_11111111};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h00000080, 64'h0, 64'h00000000_CAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h00000200, 64'h0000BBBB_0000AAAA, 64'h00000000_CAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h00000200, 64'h0, 64'h0000BBBB_0000AAAA};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h00000201, 64'h0, 64'h00000000_0000BBBB};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h00000055, 64'h0, 64'h00000000_5A5A5A0F};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h00000007, 64'h0, 64'h00000000_5A5A5A5D};

    mem_model[32'h10] = 32'hA5A5A5A5;
    mem_model[32'h20] = 32'hDEADBEEF;
    mem_model[32'h40] = 32'h11111111;
    mem_model[32'h41] = 32'h22222222;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({mem_read, mem_write, busy, beat, if_valid, dm_valid, dm_err}), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check("rst_if_rdata", 64'(if_rdata), 64'h0);
    check("rst_dm_rdata", dm_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table of single accesses, ready tied high
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      push_access(vecs[i].is_dm, vecs[i].we, vecs[i].dbl, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      issue(vecs[i], lat);
      check($sformatf("latency_v%0d", i), 64'(lat), vecs[i].dbl ? 64'd3 : 64'd2);
    end
    @(posedge clk); #1;
    check("if_rdata_hold", 64'(if_rdata), 64'h5A5A5A0F);

    // Contention: data wins, fetch granted in the dm_valid cycle
    @(posedge clk); #1;
    push_access(1'b1, 1'b0, 1'b0, 32'h20, 64'h0, 64'h00000000_DEADBEEF);
    push_access(1'b0, 1'b0, 1'b0, 32'h30, 64'h0, 64'h00000000_5A5A5A6A);
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_dbl = 1'b0; dm_addr = 32'h20;
    ld = 0; li = 0;
    for (int k = 1; k <= 40 && li == 0; k++) begin
      @(posedge clk); #1;
      if (dm_valid) begin ld = k; dm_req = 1'b0; end
      if (if_valid) begin li = k; if_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("contend_dm_lat", 64'(ld), 64'd2);
    check("contend_if_lat", 64'(li), 64'd4);

`ifndef MEM_ARB_ALIGN_CHK_EN
    // SDW at the top of the address space, two wait states per beat
    ws = 2;
    @(posedge clk); #1;
    push_access(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 64'h87654321_12345678, 64'h00000000_DEADBEEF);
    dm_req = 1'b1; dm_we = 1'b1; dm_dbl = 1'b1; dm_addr = 32'hFFFFFFFF; dm_wdata = 64'h87654321_12345678;
    n0 = 0; n1 = 0; lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (mem_write && mem_addr == 32'hFFFFFFFF) n0++;
      if (mem_write && mem_addr == 32'h00000000) n1++;
      if (dm_valid) lat = k;
    end
    dm_req = 1'b0;
    check("sdw_hold_b0", 64'(n0), 64'd3);
    check("sdw_hold_b1", 64'(n1), 64'd3);
    check("sdw_latency", 64'(lat), 64'd7);
    check("sdw_mem_wrap", 64'(mem_rd(32'h0)), 64'h87654321);
    ws = 0;
`else
    // Misaligned LDW is rejected without a memory access
    @(posedge clk); #1;
    resp_q.push_back('{1'b1, 1'b1, 64'h00000000_DEADBEEF});
    issue('{1'b1, 1'b0, 1'b1, 32'h00000041, 64'h0, 64'h0}, lat);
    check("misalign_latency", 64'(lat), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("misalign_idle", 64'({busy, mem_read, mem_write}), 64'h0);
`endif

    // Reset during the second beat of an LDW aborts it
    ws = 2;
    @(posedge clk); #1;
    beat_q.push_back('{32'h40, 1'b0, 32'h0, 1'b0});
    dm_req = 1'b1; dm_we = 1'b0; dm_dbl = 1'b1; dm_addr = 32'h40;
    seen_b1 = 1'b0;
    for (int k = 1; k <= 40 && !seen_b1; k++) begin
      @(posedge clk); #1;
      if (beat) seen_b1 = 1'b1;
    end
    check("abort_reached_b1", 64'(seen_b1), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_strobes", 64'({mem_read, mem_write}), 64'h0);
    check("abort_busy_beat", 64'({busy, beat}), 64'h0);
    check("abort_dm_rdata", dm_rdata, 64'h0);
    dm_req = 1'b0;
    ws = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_idle", 64'({busy, dm_valid, if_valid}), 64'h0);

    check("sb_resp_empty", 64'(resp_q.size()), 64'd0);
    check("sb_beat_empty", 64'(beat_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
